// File: rtl/xeng_vacc.sv
// xeng_vacc: vector integrator behind the X-engine complex MAC chain.
// Each slot of a VEC_LEN-word vector is summed over ACC_LEN vectors. At every
// integration boundary the finished words are streamed out with their address.
module xeng_vacc #(
  parameter int IN_WIDTH     = 12,
  parameter int ACC_WIDTH    = 32,
  parameter int VEC_LEN_BITS = 4,
  parameter int ACC_LEN_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*IN_WIDTH-1:0]   din,
  input  logic                    din_valid,
  input  logic                    sync,
  output logic [2*ACC_WIDTH-1:0]  dout,
  output logic [VEC_LEN_BITS-1:0] dout_addr,
  output logic                    dout_valid,
  output logic                    ovf
);

  localparam int VEC_LEN = 1 << VEC_LEN_BITS;

  localparam logic [VEC_LEN_BITS-1:0] IDX_LAST = {VEC_LEN_BITS{1'b1}};
  localparam logic [ACC_LEN_BITS-1:0] CNT_LAST = {ACC_LEN_BITS{1'b1}};
  localparam logic [ACC_WIDTH-1:0]    ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]    ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RUN
  } state_e;

  state_e                    state_q, state_d;
  logic [VEC_LEN_BITS-1:0]   idx_q, idx_d;
  logic [ACC_LEN_BITS-1:0]   cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic [2*ACC_WIDTH-1:0]    dout_q, dout_d;
  logic [VEC_LEN_BITS-1:0]   doutAddr_q, doutAddr_d;
  logic                      doutValid_q, doutValid_d;

  logic [2*ACC_WIDTH-1:0]    mem_q [VEC_LEN];

  logic                      memWe;
  logic [VEC_LEN_BITS-1:0]   memWaddr;
  logic [2*ACC_WIDTH-1:0]    memWdata;
  logic [2*ACC_WIDTH-1:0]    memRd;

  logic [ACC_WIDTH-1:0]      inRe, inIm;
  logic [ACC_WIDTH-1:0]      accRe, accIm;
  logic [ACC_WIDTH:0]        sumRe, sumIm;
  logic                      clampRe, clampIm;
  logic [ACC_WIDTH-1:0]      satRe, satIm;

  // Sign-extended input parts and the current slot's running sums
  assign inRe  = {{(ACC_WIDTH-IN_WIDTH){din[2*IN_WIDTH-1]}}, din[2*IN_WIDTH-1:IN_WIDTH]};
  assign inIm  = {{(ACC_WIDTH-IN_WIDTH){din[IN_WIDTH-1]}}, din[IN_WIDTH-1:0]};
  assign memRd = mem_q[idx_q];
  assign accRe = memRd[2*ACC_WIDTH-1:ACC_WIDTH];
  assign accIm = memRd[ACC_WIDTH-1:0];

  // One extra bit of headroom; disagreement of the top two bits means overflow
  assign sumRe   = {accRe[ACC_WIDTH-1], accRe} + {inRe[ACC_WIDTH-1], inRe};
  assign sumIm   = {accIm[ACC_WIDTH-1], accIm} + {inIm[ACC_WIDTH-1], inIm};
  assign clampRe = sumRe[ACC_WIDTH] ^ sumRe[ACC_WIDTH-1];
  assign clampIm = sumIm[ACC_WIDTH] ^ sumIm[ACC_WIDTH-1];
  assign satRe   = clampRe ? (sumRe[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sumRe[ACC_WIDTH-1:0];
  assign satIm   = clampIm ? (sumIm[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sumIm[ACC_WIDTH-1:0];

  // Next-state: sync restarts from slot 0, first vector overwrites (dumping in RUN), others accumulate
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    dout_d      = dout_q;
    doutAddr_d  = doutAddr_q;
    doutValid_d = 1'b0;
    memWe       = 1'b0;
    memWaddr    = idx_q;
    memWdata    = memRd;

    if (din_valid) begin
      if (sync) begin
        state_d  = FIRST;
        idx_d    = {{(VEC_LEN_BITS-1){1'b0}}, 1'b1};
        cnt_d    = '0;
        ovf_d    = 1'b0;
        memWe    = 1'b1;
        memWaddr = '0;
        memWdata = {inRe, inIm};
      end else if (state_q != IDLE) begin
        memWe = 1'b1;
        if (cnt_q == '0) begin
          memWdata = {inRe, inIm};
          if (state_q == RUN) begin
            doutValid_d = 1'b1;
            dout_d      = memRd;
            doutAddr_d  = idx_q;
          end
        end else begin
          memWdata = {satRe, satIm};
          if (clampRe || clampIm) begin
            ovf_d = 1'b1;
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          cnt_d = cnt_q + 1'b1;
          if ((cnt_q == CNT_LAST) && (state_q == FIRST)) begin
            state_d = RUN;
          end
        end
      end
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      dout_q      <= '0;
      doutAddr_q  <= '0;
      doutValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      dout_q      <= dout_d;
      doutAddr_q  <= doutAddr_d;
      doutValid_q <= doutValid_d;
    end
  end

  // Accumulator storage; contents are don't-care after reset so it has none
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[memWaddr] <= memWdata;
    end
  end

  assign dout       = dout_q;
  assign dout_addr  = doutAddr_q;
  assign dout_valid = doutValid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_xeng_vacc.sv
// tb_xeng_vacc: directed bench for the vector integrator with 4-word vectors,
// 4-vector integrations and a 13-bit accumulator so saturation is reachable.
module tb_xeng_vacc;

  localparam int IW = 12;
  localparam int AW = 13;
  localparam int VB = 2;
  localparam int AB = 2;

  logic              clk;
  logic              rst_n;
  logic [2*IW-1:0]   din;
  logic              din_valid;
  logic              sync;
  logic [2*AW-1:0]   dout;
  logic [VB-1:0]     dout_addr;
  logic              dout_valid;
  logic              ovf;

  int                compared   = 0;
  int                mismatched = 0;
  logic [2*AW-1:0]   holdDout;
  int                holdAddr;

  xeng_vacc #(
    .IN_WIDTH     (IW),
    .ACC_WIDTH    (AW),
    .VEC_LEN_BITS (VB),
    .ACC_LEN_BITS (AB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_valid (dout_valid),
    .ovf        (ovf)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*AW-1:0] pack(input int re, input int im);
    logic [AW-1:0] r;
    logic [AW-1:0] i;
    r = re[AW-1:0];
    i = im[AW-1:0];
    return {r, i};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on the falling edge, then settle just past the rising edge
  task automatic applyStimulus(input logic v, input logic s, input int re, input int im);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    din       = {re[IW-1:0], im[IW-1:0]};
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs; without a dump, dout/dout_addr must hold the last dump
  task automatic checkStep(input string tag, input bit expValid, input int expRe,
                           input int expIm, input int expAddr, input bit expOvf);
    if (expValid) begin
      holdDout = pack(expRe, expIm);
      holdAddr = expAddr;
    end
    checkOutput({tag, ".valid"}, 64'(dout_valid), 64'(expValid));
    checkOutput({tag, ".dout"},  64'(dout),       64'(holdDout));
    checkOutput({tag, ".addr"},  64'(dout_addr),  64'(holdAddr));
    checkOutput({tag, ".ovf"},   64'(ovf),        64'(expOvf));
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sync      = 1'b0;
    holdDout  = '0;
    holdAddr  = 0;

    // Reset state
    @(posedge clk);
    #1;
    checkStep("reset", 1'b0, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Words before any sync are ignored
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 1'b0, 9, 9);
      checkStep($sformatf("idle%0d", n), 1'b0, 0, 0, 0, 1'b0);
    end

    // Continuous {1,-1}: dumps of {4,-4} at samples 17..20 and 33..36
    for (int n = 0; n < 36; n++) begin
      applyStimulus(1'b1, n == 0, 1, -1);
      checkStep($sformatf("cont%0d", n), (n >= 16) && ((n % 16) < 4), 4, -4, n % 4, 1'b0);
    end

    // real=k, imag=0 with a gap after every sample; gaps carry a stray sync
    for (int n = 0; n < 36; n++) begin
      applyStimulus(1'b1, n == 0, n % 4, 0);
      checkStep($sformatf("gap%0d", n), (n >= 16) && ((n % 16) < 4), 4 * (n % 4), 0, n % 4, 1'b0);
      applyStimulus(1'b0, 1'b1, 99, 99);
      checkStep($sformatf("gapidle%0d", n), 1'b0, 0, 0, 0, 1'b0);
    end

    // Nine samples of {7,7}, then resync with {1,2}; only post-resync data shows
    for (int n = 0; n < 9; n++) begin
      applyStimulus(1'b1, n == 0, 7, 7);
      checkStep($sformatf("pre%0d", n), 1'b0, 0, 0, 0, 1'b0);
    end
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, n == 0, 1, 2);
      checkStep($sformatf("resync%0d", n), n >= 16, 4, 8, n % 4, 1'b0);
    end

    // Saturation: first clamp on sample 8 (third visit to word 0)
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, n == 0, 2047, -2048);
      checkStep($sformatf("sat%0d", n), n >= 16, 4095, -4096, n % 4, n >= 8);
    end

    // Asynchronous reset between edges while a dump and ovf are showing
    #2;
    rst_n = 1'b0;
    #1;
    holdDout = '0;
    holdAddr = 0;
    checkStep("asyncrst", 1'b0, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset, data without sync produces nothing
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, 1'b0, 3, 3);
      checkStep($sformatf("postrst%0d", n), 1'b0, 0, 0, 0, 1'b0);
    end

    // sync restarts a full first integration, then the next sync clears ovf
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, n == 0, 2047, -2048);
      checkStep($sformatf("restart%0d", n), n >= 16, 4095, -4096, n % 4, n >= 8);
    end
    applyStimulus(1'b1, 1'b1, 0, 0);
    checkStep("ovfclear", 1'b0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
